// File: rtl/maxpool_25_16_2.sv
// maxpool_25_16_2: window-2 / stride-2 signed max pooling over N-element vectors with valid/ready handshakes.
// Define MAXPOOL_RELU_EN to clamp every accepted element to max(x,0) before pooling.
module maxpool_25_16_2 #(
  parameter int T = 16,
  parameter int N = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready
);
  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  typedef enum logic {EMPTY, HALF} state_t;
  state_t state;
  logic [PW-1:0] pos;
  logic signed [T-1:0] hold, xc, res;
  logic last, x_fire, load, start_pair;
`ifdef MAXPOOL_RELU_EN
  assign xc = x_data[T-1] ? '0 : x_data;
`else
  assign xc = x_data;
`endif
  // Opening a pair never produces output, so it needs no room downstream.
  always_comb begin
    last       = pos == LAST;
    start_pair = state == EMPTY && !last;
    x_ready    = start_pair || !y_valid || y_ready;
    x_fire     = x_valid && x_ready;
    load       = x_fire && !start_pair;
    res        = (state == HALF && hold > xc) ? hold : xc;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      pos     <= '0;
      hold    <= '0;
      y_data  <= '0;
      y_valid <= 1'b0;
    end else begin
      if (x_fire) begin
        pos   <= last ? '0 : pos + 1'b1;
        state <= start_pair ? HALF : EMPTY;
        if (start_pair) hold <= xc;
      end
      if (load) y_data <= res;
      y_valid <= load || (y_valid && !y_ready);
    end
  end
endmodule

// File: tb/tb_maxpool_25_16_2.sv
// tb_maxpool_25_16_2: directed and randomized checks of maxpool_25_16_2 against a vector-level pooling model.
module tb_maxpool_25_16_2;
  localparam int N = 25;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] x_data, y_data;
  logic x_valid, x_ready, y_valid, y_ready;
  logic rnd;
  int checks = 0, errors = 0, out_cnt = 0, idx = 0;
  logic [15:0] vec [N];
  logic [15:0] exp_q [$];
  logic [15:0] got [$];
  logic stall_prev = 1'b0;
  logic [15:0] prev_d;
  logic [15:0] a, b, c, d;

  maxpool_25_16_2 dut (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cl(input logic [15:0] v);
`ifdef MAXPOOL_RELU_EN
    return ($signed(v) < 0) ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [15:0] mx(input logic [15:0] p, input logic [15:0] q);
    return (int'($signed(p)) >= int'($signed(q))) ? p : q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: pooled values per vector from accepted elements; compared in order at every output transfer.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      idx = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("hold_stable", {15'd0, y_valid, y_data}, {15'd0, 1'b1, prev_d});
      if (y_valid && y_ready) begin
        chk("y_data", {16'd0, y_data}, exp_q.size() > 0 ? {16'd0, exp_q[0]} : 32'hxxxxxxxx);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got.push_back(y_data);
        out_cnt++;
      end
      if (x_valid && x_ready) begin
        vec[idx] = cl(x_data);
        if (idx % 2 == 1) exp_q.push_back(mx(vec[idx-1], vec[idx]));
        else if (idx == N - 1) exp_q.push_back(vec[idx]);
        idx = (idx == N - 1) ? 0 : idx + 1;
      end
      stall_prev = y_valid && !y_ready;
      prev_d = y_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    if (rnd) y_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [15:0] v);
    x_data = v;
    x_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (x_ready) break;
      if (n == 500) begin
        checks++;
        errors++;
        $error("FAIL send_timeout: observed x_ready=0 for %0d cycles expected 1", n);
        break;
      end
      tick();
    end
    tick();
    x_valid = 1'b0;
  endtask

  initial begin
    rnd = 1'b0;
    x_valid = 1'b0;
    x_data = 16'h0;
    y_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("reset_y_valid", {31'd0, y_valid}, 32'd0);
    chk("reset_y_data", {16'd0, y_data}, 32'd0);
    chk("reset_x_ready", {31'd0, x_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    y_ready = 1'b1;

    // Ramp vector followed by a random vector, streamed back to back.
    got.delete();
    x_valid = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      x_data = (i < N) ? 16'(i) : 16'($urandom);
      @(negedge clk);
      chk("stream_x_ready", {31'd0, x_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("stream_y_valid", {31'd0, y_valid}, {31'd0, ((i % N) % 2 == 1) || (i % N == N - 1)});
    end
    x_valid = 1'b0;
    tick();
    tick();
    chk("ramp_count", got.size(), 32'd26);
    for (int k = 0; k < 13; k++) chk("ramp_out", {16'd0, got[k]}, (k < 12) ? 2 * k + 1 : 24);

    // Signed corner pairs.
    got.delete();
    send(16'hfffb);
    send(16'hfffd);
    send(16'h8000);
    send(16'h7fff);
    tick();
    tick();
    chk("corner_count", got.size(), 32'd2);
`ifdef MAXPOOL_RELU_EN
    chk("neg_pair", {16'd0, got[0]}, 32'h0000);
`else
    chk("neg_pair", {16'd0, got[0]}, 32'hfffd);
`endif
    chk("extreme_pair", {16'd0, got[1]}, 32'h7fff);
    for (int i = 4; i < N; i++) send(16'($urandom));
    tick();
    tick();
    chk("drain_corner", exp_q.size(), 32'd0);

    // Downstream stall with a held result and a half-built pair.
    y_ready = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    c = 16'($urandom);
    d = 16'($urandom);
    send(a);
    send(b);
    send(c);
    x_data = d;
    x_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_x_ready", {31'd0, x_ready}, 32'd0);
      chk("stall_y_valid", {31'd0, y_valid}, 32'd1);
      chk("stall_y_data", {16'd0, y_data}, {16'd0, mx(cl(a), cl(b))});
      @(posedge clk);
      #1;
    end
    y_ready = 1'b1;
    @(negedge clk);
    chk("resume_x_ready", {31'd0, x_ready}, 32'd1);
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    #1;
    chk("resume_y_data", {16'd0, y_data}, {16'd0, mx(cl(c), cl(d))});
    for (int i = 4; i < N; i++) send(16'($urandom));
    tick();
    tick();
    chk("drain_stall", exp_q.size(), 32'd0);

    // Randomized handshakes over 312 vectors.
    out_cnt = 0;
    rnd = 1'b1;
    for (int v = 0; v < 312; v++)
      for (int e = 0; e < N; e++) begin
        if ($urandom_range(0, 1) == 1) begin
          x_valid = 1'b0;
          x_data = 16'($urandom);
          tick();
        end
        send(16'($urandom));
      end
    rnd = 1'b0;
    y_ready = 1'b1;
    repeat (4) tick();
    chk("random_out_count", out_cnt, 32'd4056);
    chk("random_drain", exp_q.size(), 32'd0);

    // Reset in HALF at pos 7 with an undelivered result.
    for (int i = 0; i < 5; i++) send(16'($urandom));
    y_ready = 1'b0;
    send(16'($urandom));
    send(16'($urandom));
    #2 reset = 1'b1;
    #1;
    chk("midreset_y_valid", {31'd0, y_valid}, 32'd0);
    chk("midreset_y_data", {16'd0, y_data}, 32'd0);
    chk("midreset_x_ready", {31'd0, x_ready}, 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    y_ready = 1'b1;
    out_cnt = 0;
    for (int i = 0; i < N; i++) send(16'($urandom));
    repeat (3) tick();
    chk("postreset_count", out_cnt, 32'd13);
    chk("postreset_drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
